alu_res_station: RTL
====================

ALU_RES_STATION -- requirements
Module: alu_res_station

Interface
REQ-001 Parameter: DEPTH, 4, number of entries; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 dispatch  input  1  rename delivers one instruction this cycle.
REQ-005 rs_in  input  rs_t  renamed instruction: operands r1_v/r2_v, busy_1/busy_2, rs1_rob/rs2_rob, rob_entry, aluop, opcode, pc, imm.
REQ-006 cdb1..cdb4  input  cdb_t each  broadcast buses: valid, tag[3:0], value[31:0].
REQ-007 flush  input  1  synchronous squash of all entries (mispredict).
REQ-008 fu_ready  input  1  ALU accepts an issued packet this cycle.
REQ-009 rs_full  output  1  no free entry; drives the rename-stage rs_full1 input.
REQ-010 issue_valid  output  1  issue_pkt holds a fully-ready instruction.
REQ-011 issue_pkt  output  rs_t  instruction to ALU; busy_1=busy_2=0, operands resolved.

Function
REQ-012 Each entry SHALL hold valid bit plus one rs_t; entry ready = valid && !busy_1 && !busy_2.
REQ-013 Dispatch SHALL write rs_in into the lowest-index invalid entry when dispatch && !rs_full; dispatch while rs_full SHALL be ignored with no state change.
REQ-014 rs_full SHALL be combinational from registered valid bits only: all DEPTH entries valid.
REQ-015 CDB snoop: for each valid entry with busy_x=1, any cdbN.valid with tag==rsx_rob SHALL load value into rx_v and clear busy_x at the next edge; lowest N wins if several match.
REQ-016 Insert bypass: an incoming operand with busy_x=1 whose tag matches a valid CDB in the dispatch cycle SHALL be stored with busy_x=0 and the CDB value.
REQ-017 Issue selection SHALL be combinational: issue_valid=1 when any entry ready; issue_pkt = lowest-index ready entry.
REQ-018 Issue handshake: when issue_valid && fu_ready, the selected entry SHALL be invalidated at the next edge; otherwise it SHALL hold, and issue_pkt SHALL remain stable.
REQ-019 An operand woken by CDB SHALL NOT issue in the same cycle as the wakeup (1-cycle wakeup-to-issue latency); dispatch-to-issue minimum latency is 1 cycle.
REQ-020 Same-cycle issue and dispatch SHALL both take effect; the freed slot is unavailable to that dispatch (rs_full evaluated before issue).
REQ-021 flush SHALL clear all valid bits at the next edge and take priority over dispatch, snoop and issue in that cycle.
REQ-022 When issue_valid=0, issue_pkt SHALL be all zeros.

Reset
REQ-023 Asserting rst SHALL immediately clear all valid bits; rs_full=0, issue_valid=0, issue_pkt=0 while rst is high.
REQ-024 Entry payloads need not be reset; only valid bits are reset-significant.
REQ-025 Reset mid-operation SHALL discard all pending entries; first post-reset dispatch goes to entry 0.

Structure
REQ-026 rs_t, cdb_t and constant RS_DEPTH SHALL live in the shared rv32i_types package; no new typedefs local to the module.
REQ-027 One sub-module rs_entry (single-slot storage plus 4-bus CDB compare/wakeup) SHALL be instantiated DEPTH times; select and allocate logic stay in the top.

Verification
REQ-028 Dispatch rs_in with busy_1=busy_2=0, fu_ready=1 -> issue_valid=1 the next cycle, entry freed the cycle after.
REQ-029 Dispatch busy_1=1 rs1_rob=5; two cycles later cdb3={1,5,0xDEADBEEF} -> next cycle issue_pkt.r1_v=0xDEADBEEF, busy_1=0, issue_valid=1.
REQ-030 Dispatch busy_2=1 rs2_rob=7 with cdb1={1,7,0x12} in the same cycle -> issues next cycle with r2_v=0x12.
REQ-031 Fill 4 entries with fu_ready=0 -> rs_full=1; 5th dispatch ignored; one fu_ready pulse -> rs_full=0 next cycle, entry 0 issued first.
REQ-032 Entries 1 and 3 ready, entry 0 busy -> issue_pkt from entry 1; after handshake, entry 3.
REQ-033 Assert flush with 3 entries valid and simultaneous dispatch -> all invalid next cycle, issue_valid=0, rs_full=0; async rst mid-stream likewise clears outputs immediately.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I out-of-order types: renamed-instruction payload, CDB broadcast
// bus, reservation-station depth, and the CDB wakeup helper.
//   rs_t       : operands r1_v/r2_v, busy flags, source ROB tags, rob_entry,
//                aluop, opcode, pc, imm
//   cdb_t      : valid, tag, value
//   cdb_wakeup : resolves busy operands against four CDB buses
package rv32i_types;

    localparam int unsigned RS_DEPTH = 4;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned NUM_CDB  = 4;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } cdb_t;

    typedef struct packed {
        logic [XLEN-1:0]  r1_v;
        logic [XLEN-1:0]  r2_v;
        logic             busy_1;
        logic             busy_2;
        logic [TAG_W-1:0] rs1_rob;
        logic [TAG_W-1:0] rs2_rob;
        logic [TAG_W-1:0] rob_entry;
        logic [3:0]       aluop;
        logic [6:0]       opcode;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
    } rs_t;

    // Walk buses from highest to lowest so the lowest-numbered match is the
    // last write and therefore wins.
    function automatic rs_t cdb_wakeup(input rs_t e, input cdb_t c1, input cdb_t c2,
                                       input cdb_t c3, input cdb_t c4);
        cdb_t bus [NUM_CDB];
        rs_t  r;
        bus[0] = c1;
        bus[1] = c2;
        bus[2] = c3;
        bus[3] = c4;
        r = e;
        for (int n = int'(NUM_CDB) - 1; n >= 0; n--) begin
            if (e.busy_1 && bus[n].valid && (bus[n].tag == e.rs1_rob)) begin
                r.r1_v   = bus[n].value;
                r.busy_1 = 1'b0;
            end
            if (e.busy_2 && bus[n].valid && (bus[n].tag == e.rs2_rob)) begin
                r.r2_v   = bus[n].value;
                r.busy_2 = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_res_station_if.sv
// Reservation-station bus bundle between rename/CDB/ALU (master) and the
// station (slave).
//   dispatch/rs_in      : rename delivers one instruction
//   cdb1..cdb4          : result broadcast buses
//   flush               : squash all entries
//   fu_ready            : ALU accepts issue_pkt
//   rs_full             : no free entry
//   issue_valid/pkt     : ready instruction toward the ALU
interface alu_res_station_if;

    logic                   dispatch;
    rv32i_types::rs_t       rs_in;
    rv32i_types::cdb_t      cdb1;
    rv32i_types::cdb_t      cdb2;
    rv32i_types::cdb_t      cdb3;
    rv32i_types::cdb_t      cdb4;
    logic                   flush;
    logic                   fu_ready;
    logic                   rs_full;
    logic                   issue_valid;
    rv32i_types::rs_t       issue_pkt;

    modport master (
        output dispatch, rs_in, cdb1, cdb2, cdb3, cdb4, flush, fu_ready,
        input  rs_full, issue_valid, issue_pkt
    );

    modport slave (
        input  dispatch, rs_in, cdb1, cdb2, cdb3, cdb4, flush, fu_ready,
        output rs_full, issue_valid, issue_pkt
    );

endinterface

// File: rtl/rs_entry.sv
// Single reservation-station slot: valid bit, payload, and CDB snoop.
//   i_load   : write i_data (with same-cycle CDB bypass)
//   i_clear  : entry issued, drop it
//   i_flush  : squash, overrides load/clear
//   i_cdb1-4 : broadcast buses snooped every cycle
//   o_valid  : slot occupied
//   o_ready  : occupied with both operands resolved
//   o_data   : stored payload
module rs_entry
    import rv32i_types::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_clear,
    input  logic i_flush,
    input  rs_t  i_data,
    input  cdb_t i_cdb1,
    input  cdb_t i_cdb2,
    input  cdb_t i_cdb3,
    input  cdb_t i_cdb4,
    output logic o_valid,
    output logic o_ready,
    output rs_t  o_data
);

    logic r_valid;
    rs_t  r_data;

    // Occupancy; flush beats everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    // Payload carries no reset; ready depends on r_valid, so stale data is harmless.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_data <= cdb_wakeup(i_data, i_cdb1, i_cdb2, i_cdb3, i_cdb4);
        end else begin
            r_data <= cdb_wakeup(r_data, i_cdb1, i_cdb2, i_cdb3, i_cdb4);
        end
    end

    // Ready is taken from registered state only, giving the 1-cycle wakeup latency.
    assign o_valid = r_valid;
    assign o_ready = r_valid && !r_data.busy_1 && !r_data.busy_2;
    assign o_data  = r_data;

endmodule

// File: rtl/alu_res_station.sv
// ALU reservation station: DEPTH slots, lowest-free allocation, lowest-ready
// issue, CDB wakeup inside each slot.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of alu_res_station_if (dispatch, rs_in, cdb1..4,
//              flush, fu_ready in; rs_full, issue_valid, issue_pkt out)
module alu_res_station
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = RS_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    alu_res_station_if.slave   bus
);

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_alloc_oh;
    logic [DEPTH-1:0] w_issue_oh;
    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_clear;
    rs_t              w_data [DEPTH];
    rs_t              w_issue_pkt;
    logic             w_alloc_found;
    logic             w_issue_found;
    logic             w_full;

    // Full uses registered valid bits only, so a slot freed this cycle is not reusable yet.
    assign w_full = &w_valid;

    // Priority pick of lowest free slot and lowest ready slot.
    always_comb begin
        w_alloc_oh    = '0;
        w_issue_oh    = '0;
        w_issue_pkt   = '0;
        w_alloc_found = 1'b0;
        w_issue_found = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!w_alloc_found && !w_valid[i]) begin
                w_alloc_found = 1'b1;
                w_alloc_oh[i] = 1'b1;
            end
            if (!w_issue_found && w_ready[i]) begin
                w_issue_found = 1'b1;
                w_issue_oh[i] = 1'b1;
                w_issue_pkt   = w_data[i];
            end
        end
    end

    assign w_load  = w_alloc_oh & {DEPTH{bus.dispatch && !w_full}};
    assign w_clear = w_issue_oh & {DEPTH{bus.fu_ready}};

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_entry
            rs_entry u_entry (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_load[g]),
                .i_clear (w_clear[g]),
                .i_flush (bus.flush),
                .i_data  (bus.rs_in),
                .i_cdb1  (bus.cdb1),
                .i_cdb2  (bus.cdb2),
                .i_cdb3  (bus.cdb3),
                .i_cdb4  (bus.cdb4),
                .o_valid (w_valid[g]),
                .o_ready (w_ready[g]),
                .o_data  (w_data[g])
            );
        end
    endgenerate

    assign bus.rs_full     = w_full;
    assign bus.issue_valid = w_issue_found;
    assign bus.issue_pkt   = w_issue_pkt;

endmodule
